// File: rtl/imm_pkg.sv
// Shared immediate-format codes, instruction field positions and pipeline payload types,
// used by both the encoder and the decoder.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I     = 3'd0,
        FMT_S     = 3'd1,
        FMT_B     = 3'd2,
        FMT_U     = 3'd3,
        FMT_J     = 3'd4,
        FMT_SHAMT = 3'd5,
        FMT_ZIMM  = 3'd6
    } fmt_e;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int CSR_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef struct packed {
        logic range_err;
        logic align_err;
        logic fmt_err;
    } flags_t;

    // Only imm[31:0] is kept past S1; the upper bits matter only to the range check.
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        flags_t      flags;
    } s1_t;

    // True when imm[63:lsb] are all ones or all zeros, i.e. the value sign-extends from bit lsb.
    function automatic logic uniform_above(input logic [63:0] v, input int lsb);
        logic [63:0] m;
        m = {64{1'b1}} << lsb;
        return ((v & m) == m) || ((v & m) == 64'd0);
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational range/alignment/format screen of a 64-bit immediate against its target format;
// no latency, no flow control.
module imm_range_check
    import imm_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [63:0] imm,
    output logic        range_err,
    output logic        align_err,
    output logic        fmt_err
);

    always_comb begin
        range_err = 1'b0;
        align_err = 1'b0;
        fmt_err   = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = !uniform_above(imm, 11);
            FMT_B: begin
                range_err = !uniform_above(imm, 12);
                align_err = imm[0];
            end
            FMT_U: begin
                range_err = !uniform_above(imm, 31);
                align_err = |imm[11:0];
            end
            FMT_J: begin
                range_err = !uniform_above(imm, 20);
                align_err = imm[0];
            end
            FMT_SHAMT: range_err = |imm[63:6];
            FMT_ZIMM:  range_err = |imm[63:5];
            default:   fmt_err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// RV immediate packer: S1 registers fields + checks, S2 registers assembled instr; 2-cycle latency, 1/cycle.
// Backpressure: S2 holds under !out_ready, S1 stalls behind it; in_ready = !s1_valid || S2 can advance.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [63:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             range_err,
    output logic             align_err,
    output logic             fmt_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] enc_count,
    output logic [7:0]       err_count
);
    import imm_pkg::*;

    s1_t              s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      instr_q, instr_d, instr_asm;
    flags_t           flags_q, flags_d;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [7:0]       err_count_q, err_count_d;

    logic   s1_adv, in_hs, out_hs;
    flags_t rc_flags;

    imm_range_check u_range_check (
        .fmt       (fmt),
        .imm       (imm),
        .range_err (rc_flags.range_err),
        .align_err (rc_flags.align_err),
        .fmt_err   (rc_flags.fmt_err)
    );

    assign s1_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_hs) begin
            s1_d.fmt    = fmt;
            s1_d.opcode = opcode;
            s1_d.funct3 = funct3;
            s1_d.funct7 = funct7;
            s1_d.rd     = rd;
            s1_d.rs1    = rs1;
            s1_d.rs2    = rs2;
            s1_d.imm    = imm[31:0];
            s1_d.flags  = rc_flags;
        end
    end

    // Out-of-range immediates are still packed, simply truncated to the field widths.
    always_comb begin
        instr_asm = 32'h0000_0000;
        instr_asm[OPC_LSB +: 7] = s1_q.opcode;
        case (s1_q.fmt)
            FMT_I: begin
                instr_asm[31:20]         = s1_q.imm[11:0];
                instr_asm[RS1_LSB +: 5]  = s1_q.rs1;
                instr_asm[F3_LSB +: 3]   = s1_q.funct3;
                instr_asm[RD_LSB +: 5]   = s1_q.rd;
            end
            FMT_S: begin
                instr_asm[31:25]         = s1_q.imm[11:5];
                instr_asm[RS2_LSB +: 5]  = s1_q.rs2;
                instr_asm[RS1_LSB +: 5]  = s1_q.rs1;
                instr_asm[F3_LSB +: 3]   = s1_q.funct3;
                instr_asm[11:7]          = s1_q.imm[4:0];
            end
            FMT_B: begin
                instr_asm[31]            = s1_q.imm[12];
                instr_asm[30:25]         = s1_q.imm[10:5];
                instr_asm[RS2_LSB +: 5]  = s1_q.rs2;
                instr_asm[RS1_LSB +: 5]  = s1_q.rs1;
                instr_asm[F3_LSB +: 3]   = s1_q.funct3;
                instr_asm[11:8]          = s1_q.imm[4:1];
                instr_asm[7]             = s1_q.imm[11];
            end
            FMT_U: begin
                instr_asm[31:12]         = s1_q.imm[31:12];
                instr_asm[RD_LSB +: 5]   = s1_q.rd;
            end
            FMT_J: begin
                instr_asm[31]            = s1_q.imm[20];
                instr_asm[30:21]         = s1_q.imm[10:1];
                instr_asm[20]            = s1_q.imm[11];
                instr_asm[19:12]         = s1_q.imm[19:12];
                instr_asm[RD_LSB +: 5]   = s1_q.rd;
            end
            FMT_SHAMT: begin
                instr_asm[31:26]         = s1_q.funct7[6:1];
                instr_asm[25:20]         = s1_q.imm[5:0];
                instr_asm[RS1_LSB +: 5]  = s1_q.rs1;
                instr_asm[F3_LSB +: 3]   = s1_q.funct3;
                instr_asm[RD_LSB +: 5]   = s1_q.rd;
            end
            FMT_ZIMM: begin
                instr_asm[CSR_LSB +: 12] = {s1_q.funct7, s1_q.rs2};
                instr_asm[19:15]         = s1_q.imm[4:0];
                instr_asm[F3_LSB +: 3]   = s1_q.funct3;
                instr_asm[RD_LSB +: 5]   = s1_q.rd;
            end
            default: instr_asm = 32'h0000_0000;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        flags_d     = flags_q;
        if (s1_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d = instr_asm;
                flags_d = s1_q.flags;
            end
        end
    end

    // Clear wins over a coincident increment; both counters stick at all-ones.
    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (cnt_clr) begin
            enc_count_d = '0;
            err_count_d = 8'h00;
        end else if (out_hs) begin
            if (!(&enc_count_q)) begin
                enc_count_d = enc_count_q + CNT_W'(1);
            end
            if ((|flags_q) && !(&err_count_q)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            instr_q     <= 32'h0000_0000;
            flags_q     <= '0;
            enc_count_q <= '0;
            err_count_q <= 8'h00;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            flags_q     <= flags_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign range_err = flags_q.range_err;
    assign align_err = flags_q.align_err;
    assign fmt_err   = flags_q.fmt_err;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed format cases, backpressure, reset, counters, and a randomized
// run scored against an arithmetic reference model of the encoding rules.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [63:0] imm = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic        range_err;
    logic        align_err;
    logic        fmt_err;
    logic        cnt_clr = 1'b0;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
    } req_t;

    typedef struct packed {
        logic [31:0] ins;
        logic        r;
        logic        a;
        logic        f;
    } exp_t;

    longint bnd [0:13] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                           63, 64, 31, 32, 1048574, -1048578};

    imm_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .range_err (range_err),
        .align_err (align_err),
        .fmt_err   (fmt_err),
        .cnt_clr   (cnt_clr),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] fld(input logic [63:0] u, input int hi, input int lo, input int pos);
        logic [63:0] m;
        m = (64'd1 << (hi - lo + 1)) - 64'd1;
        return 32'(((u >> lo) & m) << pos);
    endfunction

    function automatic bit fits_signed(input longint v, input int bits);
        longint lim;
        lim = longint'(1) << (bits - 1);
        return (v >= -lim) && (v < lim);
    endfunction

    function automatic exp_t model(input req_t q);
        exp_t        e;
        longint      v;
        logic [63:0] u;
        logic [31:0] opc, rdf, f3f, r1f, r2f;
        e   = '0;
        u   = q.imm;
        v   = $signed(q.imm);
        opc = 32'(q.opc);
        rdf = 32'(q.rd) << 7;
        f3f = 32'(q.f3) << 12;
        r1f = 32'(q.rs1) << 15;
        r2f = 32'(q.rs2) << 20;
        case (q.fmt)
            3'd0: begin
                e.r   = !fits_signed(v, 12);
                e.ins = fld(u, 11, 0, 20) | r1f | f3f | rdf | opc;
            end
            3'd1: begin
                e.r   = !fits_signed(v, 12);
                e.ins = fld(u, 11, 5, 25) | r2f | r1f | f3f | fld(u, 4, 0, 7) | opc;
            end
            3'd2: begin
                e.r   = !fits_signed(v, 13);
                e.a   = (u % 2) != 0;
                e.ins = fld(u, 12, 12, 31) | fld(u, 10, 5, 25) | r2f | r1f | f3f
                      | fld(u, 4, 1, 8) | fld(u, 11, 11, 7) | opc;
            end
            3'd3: begin
                e.r   = !fits_signed(v, 32);
                e.a   = (u % 4096) != 0;
                e.ins = fld(u, 31, 12, 12) | rdf | opc;
            end
            3'd4: begin
                e.r   = !fits_signed(v, 21);
                e.a   = (u % 2) != 0;
                e.ins = fld(u, 20, 20, 31) | fld(u, 10, 1, 21) | fld(u, 11, 11, 20)
                      | fld(u, 19, 12, 12) | rdf | opc;
            end
            3'd5: begin
                e.r   = u > 64'd63;
                e.ins = (32'(q.f7 >> 1) << 26) | fld(u, 5, 0, 20) | r1f | f3f | rdf | opc;
            end
            3'd6: begin
                e.r   = u > 64'd31;
                e.ins = (32'({q.f7, q.rs2}) << 20) | fld(u, 4, 0, 15) | f3f | rdf | opc;
            end
            default: begin
                e.f   = 1'b1;
                e.ins = 32'h0;
            end
        endcase
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic req_t mk(input logic [2:0] f, input logic [6:0] o, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [63:0] i);
        req_t q;
        q.fmt = f; q.opc = o; q.f3 = f3; q.f7 = f7; q.rd = d; q.rs1 = s1; q.rs2 = s2; q.imm = i;
        return q;
    endfunction

    function automatic logic [63:0] gen_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return 64'(longint'($urandom_range(0, 80)) - 40);
            1:       return 64'(bnd[$urandom_range(0, 13)]);
            2:       return {$urandom, $urandom};
            default: return ($urandom_range(0, 1) != 0) ? {{32{r[31]}}, r[31:12], 12'h000}
                                                         : {{32{r[31]}}, r};
        endcase
    endfunction

    function automatic req_t gen_req();
        return mk(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
                  5'($urandom), 5'($urandom), 5'($urandom), gen_imm());
    endfunction

    task automatic drive(input req_t q);
        fmt = q.fmt; opcode = q.opc; funct3 = q.f3; funct7 = q.f7;
        rd = q.rd; rs1 = q.rs1; rs2 = q.rs2; imm = q.imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    // Sends one request with out_ready high; returns outputs and handshake-to-out_valid latency.
    task automatic xact(input req_t q, output exp_t got, output int lat);
        drive(q);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        lat = 0;
        do begin
            tick();
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 10);
        got = {instr, range_err, align_err, fmt_err};
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", instr); end
        checks++; if ({range_err, align_err, fmt_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {range_err, align_err, fmt_err}); end
        checks++; if (enc_count !== 16'h0 || err_count !== 8'h0) begin errors++; $display("FAIL reset_counts: got enc %h err %h want 0 0", enc_count, err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_i_type();
        exp_t g; int lat;
        xact(mk(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF), g, lat);
        checks++; if (g.ins !== 32'hFFF10093) begin errors++; $display("FAIL i_instr: got %h want fff10093", g.ins); end
        checks++; if ({g.r, g.a, g.f} !== 3'b000) begin errors++; $display("FAIL i_flags: got %b want 000", {g.r, g.a, g.f}); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL i_latency: got %0d want 2", lat); end
        checks++; if (enc_count !== 16'd1 || err_count !== 8'd0) begin errors++; $display("FAIL i_counts: got enc %0d err %0d want 1 0", enc_count, err_count); end
    endtask

    task automatic test_b_type();
        exp_t g, e; int lat; req_t q;
        xact(mk(3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd8), g, lat);
        checks++; if (g !== {32'h00208463, 3'b000}) begin errors++; $display("FAIL b_imm8: got %h/%b want 00208463/000", g.ins, {g.r, g.a, g.f}); end
        q = mk(3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd7);
        e = model(q);
        xact(q, g, lat);
        checks++; if ({g.r, g.a, g.f} !== 3'b010) begin errors++; $display("FAIL b_align_flags: got %b want 010", {g.r, g.a, g.f}); end
        checks++; if (g.ins !== e.ins) begin errors++; $display("FAIL b_align_instr: got %h want %h", g.ins, e.ins); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL b_err_count: got %0d want 1", err_count); end
    endtask

    task automatic test_u_and_range();
        exp_t g; int lat;
        clear_counters();
        xact(mk(3'd3, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5000), g, lat);
        checks++; if (g !== {32'h123452B7, 3'b000}) begin errors++; $display("FAIL u_instr: got %h/%b want 123452b7/000", g.ins, {g.r, g.a, g.f}); end
        xact(mk(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 64'd2048), g, lat);
        checks++; if (g !== {32'h80010093, 3'b100}) begin errors++; $display("FAIL i_range: got %h/%b want 80010093/100", g.ins, {g.r, g.a, g.f}); end
        checks++; if (err_count !== 8'd1 || enc_count !== 16'd2) begin errors++; $display("FAIL range_counts: got enc %0d err %0d want 2 1", enc_count, err_count); end
    endtask

    task automatic test_fmt_err();
        exp_t g; int lat;
        xact(mk(3'd7, 7'h13, 3'd5, 7'h7F, 5'd3, 5'd4, 5'd6, 64'h8000_0000_0000_0001), g, lat);
        checks++; if (g !== {32'h0, 3'b001}) begin errors++; $display("FAIL fmt_err: got %h/%b want 00000000/001", g.ins, {g.r, g.a, g.f}); end
    endtask

    task automatic test_back_to_back();
        req_t q[4]; exp_t e[4];
        int sent = 0, got = 0, c = 0;
        for (int i = 0; i < 4; i++) begin
            q[i] = gen_req();
            e[i] = model(q[i]);
        end
        clear_counters();
        while (got < 4 && c < 40) begin
            out_ready = (c >= 3);
            in_valid  = (sent < 4);
            if (sent < 4) drive(q[sent]);
            @(negedge clk);
            if (c == 2) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_held: got %b want 0", in_ready); end
                checks++; if (out_valid !== 1'b1 || instr !== e[0].ins) begin errors++; $display("FAIL b2b_hold: got vld %b instr %h want 1 %h", out_valid, instr, e[0].ins); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({instr, range_err, align_err, fmt_err} !== e[got]) begin
                    errors++;
                    $display("FAIL b2b_out%0d: got %h/%b want %h/%b", got, instr,
                             {range_err, align_err, fmt_err}, e[got].ins, {e[got].r, e[got].a, e[got].f});
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            c++;
        end
        in_valid = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("FAIL b2b_timeout: got %0d outputs want 4", got); end
        checks++; if (enc_count !== 16'd4) begin errors++; $display("FAIL b2b_enc_count: got %0d want 4", enc_count); end
    endtask

    task automatic test_random();
        exp_t sb[$];
        req_t cur;
        bit   pend = 0;
        int   n_enc = 0, n_err = 0;
        cur = gen_req();
        clear_counters();
        for (int c = 0; c < 420; c++) begin
            if (!pend && c < 400) begin
                pend = ($urandom_range(0, 3) != 0);
                if (pend) cur = gen_req();
            end
            in_valid  = pend;
            drive(cur);
            out_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rnd_spurious: out_valid with empty scoreboard at cycle %0d", c);
                end else if (out_ready) begin
                    checks++;
                    if ({instr, range_err, align_err, fmt_err} !== sb[0]) begin
                        errors++;
                        $display("FAIL rnd_out: got %h/%b want %h/%b", instr,
                                 {range_err, align_err, fmt_err}, sb[0].ins, {sb[0].r, sb[0].a, sb[0].f});
                    end
                    n_enc++;
                    if (sb[0].r || sb[0].a || sb[0].f) n_err++;
                    void'(sb.pop_front());
                end else begin
                    checks++;
                    if ({instr, range_err, align_err, fmt_err} !== sb[0]) begin
                        errors++;
                        $display("FAIL rnd_hold: got %h want %h", instr, sb[0].ins);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(cur));
                pend = 0;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rnd_drain: %0d outputs missing want 0", sb.size()); end
        checks++; if (enc_count !== 16'(n_enc)) begin errors++; $display("FAIL rnd_enc_count: got %0d want %0d", enc_count, n_enc); end
        checks++; if (err_count !== 8'((n_err > 255) ? 255 : n_err)) begin errors++; $display("FAIL rnd_err_count: got %0d want %0d", err_count, n_err); end
    endtask

    task automatic test_reset_midflight();
        exp_t g, e; int lat; req_t q;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(gen_req());
        tick();
        drive(gen_req());
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got vld %b rdy %b want 1 0", out_valid, in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_async: got vld %b rdy %b want 0 1", out_valid, in_ready); end
        checks++; if (enc_count !== 16'd0 || err_count !== 8'd0) begin errors++; $display("FAIL mid_reset_counts: got %0d %0d want 0 0", enc_count, err_count); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard: got out_valid %b want 0", out_valid); end
        q = mk(3'd4, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'h0000_0000_0008_0ABC);
        e = model(q);
        xact(q, g, lat);
        checks++; if (g !== e || lat !== 2) begin errors++; $display("FAIL mid_after: got %h/%b lat %0d want %h/%b lat 2", g.ins, {g.r, g.a, g.f}, lat, e.ins, {e.r, e.a, e.f}); end
    endtask

    task automatic test_cnt_clr();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(mk(3'd1, 7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd4, 64'd12));
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++; if (enc_count !== 16'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clr_coincident: got enc %0d vld %b want 0 0", enc_count, out_valid); end
        drive(mk(3'd5, 7'h13, 3'd1, 7'h20, 5'd1, 5'd1, 5'd0, 64'd64));
        in_valid = 1'b1;
        for (int i = 0; i < 65600; i++) tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (enc_count !== 16'hFFFF) begin errors++; $display("FAIL enc_saturate: got %h want ffff", enc_count); end
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL err_saturate: got %h want ff", err_count); end
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_b_type();
        test_u_and_range();
        test_fmt_err();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_cnt_clr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
